// File: rtl/mem_access_unit_pkg.sv
// Shared widths, funct3 encodings, FSM state codes and access-legality helpers
// for the MEM-stage data-memory access unit.
package mem_access_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_REQ  = 2'd1,
        MAU_RESP = 2'd2
    } mau_state_e;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return ~a[0];
            2'b10:   return (a == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_data_aligner.sv
// Picks the byte/half lane of a read word selected by the low address bits
// and sign- or zero-extends it to XLEN.
module load_data_aligner
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_H:    data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_W:    data_o = rdata_i;
            F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_sel};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns loads/stores into a req/ack bus transaction,
// stalls upstream while it is outstanding and presents the WB-bound result.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ex_mem_valid,
    input  logic            ex_mem_MemRead,
    input  logic            ex_mem_MemWrite,
    input  logic [2:0]      ex_mem_funct3,
    input  logic [XLEN-1:0] ex_mem_alu_result,
    input  logic [XLEN-1:0] ex_mem_write_data,
    input  logic            ex_mem_MemtoReg,
    input  logic            ex_mem_RegWrite,
    input  logic [4:0]      ex_mem_WriteReg,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] mem_read_data,
    output logic [XLEN-1:0] mem_alu_result,
    output logic            mem_MemtoReg,
    output logic            mem_RegWrite,
    output logic [4:0]      mem_WriteReg,
    output logic            mem_wb_enable,
    output logic            mem_stall,
    output logic            misalign_exc,
    output logic            bus_error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    mau_state_e      state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] addr_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      f3_q;
    logic            m2r_q;
    logic            rw_q;
    logic [4:0]      wreg_q;
    logic [XLEN-1:0] rdata_q;
    logic            berr_q;

    logic            mem_op;
    logic            is_store;
    logic            op_ok;
    logic [3:0]      be_calc;
    logic [XLEN-1:0] wdata_calc;
    logic [XLEN-1:0] load_fmt;

    assign mem_op   = ex_mem_valid & (ex_mem_MemRead | ex_mem_MemWrite);
    assign is_store = ex_mem_MemWrite & ~ex_mem_MemRead;
    assign op_ok    = f3_legal(is_store, ex_mem_funct3) &
                      addr_aligned(ex_mem_funct3, ex_mem_alu_result[1:0]);

    always_comb begin
        case (ex_mem_funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << ex_mem_alu_result[1:0];
                wdata_calc = {4{ex_mem_write_data[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << ex_mem_alu_result[1:0];
                wdata_calc = {2{ex_mem_write_data[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = ex_mem_write_data;
            end
        endcase
    end

    load_data_aligner u_aligner (
        .funct3_i  (f3_q),
        .addr_lo_i (addr_q[1:0]),
        .rdata_i   (dmem_rdata),
        .data_o    (load_fmt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= MAU_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            m2r_q   <= 1'b0;
            rw_q    <= 1'b0;
            wreg_q  <= '0;
            rdata_q <= '0;
            berr_q  <= 1'b0;
        end else begin
            case (state_q)
                MAU_IDLE: begin
                    if (mem_op && op_ok) begin
                        state_q <= MAU_REQ;
                        cnt_q   <= '0;
                        addr_q  <= ex_mem_alu_result;
                        we_q    <= is_store;
                        be_q    <= be_calc;
                        wdata_q <= wdata_calc;
                        f3_q    <= ex_mem_funct3;
                        m2r_q   <= ex_mem_MemtoReg;
                        rw_q    <= ex_mem_RegWrite;
                        wreg_q  <= ex_mem_WriteReg;
                        berr_q  <= 1'b0;
                    end
                end
                MAU_REQ: begin
                    if (dmem_ack) begin
                        rdata_q <= we_q ? '0 : load_fmt;
                        state_q <= MAU_RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        // last allowed wait cycle: give up and retire with a bus error
                        rdata_q <= '0;
                        rw_q    <= 1'b0;
                        berr_q  <= 1'b1;
                        state_q <= MAU_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MAU_RESP: begin
                    berr_q  <= 1'b0;
                    state_q <= MAU_IDLE;
                end
                default: state_q <= MAU_IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is asserted, including the IDLE pass-through.
    always_comb begin
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = '0;
        dmem_wdata     = '0;
        dmem_be        = '0;
        mem_read_data  = '0;
        mem_alu_result = '0;
        mem_MemtoReg   = 1'b0;
        mem_RegWrite   = 1'b0;
        mem_WriteReg   = '0;
        mem_wb_enable  = 1'b0;
        mem_stall      = 1'b0;
        misalign_exc   = 1'b0;
        bus_error      = 1'b0;
        if (reset) begin
            case (state_q)
                MAU_IDLE: begin
                    if (ex_mem_valid) begin
                        mem_alu_result = ex_mem_alu_result;
                        mem_MemtoReg   = ex_mem_MemtoReg;
                        mem_WriteReg   = ex_mem_WriteReg;
                        if (!mem_op) begin
                            mem_RegWrite  = ex_mem_RegWrite;
                            mem_wb_enable = 1'b1;
                        end else if (!op_ok) begin
                            misalign_exc  = 1'b1;
                            mem_wb_enable = 1'b1;
                        end else begin
                            mem_stall = 1'b1;
                        end
                    end
                end
                MAU_REQ: begin
                    dmem_req   = 1'b1;
                    dmem_we    = we_q;
                    dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
                    dmem_be    = be_q;
                    dmem_wdata = wdata_q;
                    mem_stall  = 1'b1;
                end
                MAU_RESP: begin
                    mem_read_data  = rdata_q;
                    mem_alu_result = addr_q;
                    mem_MemtoReg   = m2r_q;
                    mem_RegWrite   = rw_q;
                    mem_WriteReg   = wreg_q;
                    mem_wb_enable  = 1'b1;
                    bus_error      = berr_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases with literal expectations, then
// randomized instruction streams checked every cycle against a transaction model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        ex_mem_valid, ex_mem_MemRead, ex_mem_MemWrite;
    logic [2:0]  ex_mem_funct3;
    logic [31:0] ex_mem_alu_result, ex_mem_write_data;
    logic        ex_mem_MemtoReg, ex_mem_RegWrite;
    logic [4:0]  ex_mem_WriteReg;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] mem_read_data, mem_alu_result;
    logic        mem_MemtoReg, mem_RegWrite;
    logic [4:0]  mem_WriteReg;
    logic        mem_wb_enable, mem_stall, misalign_exc, bus_error;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clock             (clk),
        .reset             (rst_n),
        .ex_mem_valid      (ex_mem_valid),
        .ex_mem_MemRead    (ex_mem_MemRead),
        .ex_mem_MemWrite   (ex_mem_MemWrite),
        .ex_mem_funct3     (ex_mem_funct3),
        .ex_mem_alu_result (ex_mem_alu_result),
        .ex_mem_write_data (ex_mem_write_data),
        .ex_mem_MemtoReg   (ex_mem_MemtoReg),
        .ex_mem_RegWrite   (ex_mem_RegWrite),
        .ex_mem_WriteReg   (ex_mem_WriteReg),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_be           (dmem_be),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .mem_read_data     (mem_read_data),
        .mem_alu_result    (mem_alu_result),
        .mem_MemtoReg      (mem_MemtoReg),
        .mem_RegWrite      (mem_RegWrite),
        .mem_WriteReg      (mem_WriteReg),
        .mem_wb_enable     (mem_wb_enable),
        .mem_stall         (mem_stall),
        .misalign_exc      (misalign_exc),
        .bus_error         (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // expected values for the current cycle, plus which groups are meaningful
    logic        chk_on = 1'b0;
    logic        e_en, e_stall, e_req, e_exc, e_berr, e_we, e_m2r, e_rw;
    logic [31:0] e_addr, e_wdata, e_alu, e_rd;
    logic [3:0]  e_be;
    logic [4:0]  e_wreg;
    logic        ck_bus, ck_wd, ck_wb, ck_rw, ck_rd;

    int          stall_cycles, req_cycles;
    logic [31:0] obs_rd, obs_alu, obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic [4:0]  obs_wreg;
    logic        obs_rw, obs_berr, obs_exc;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("mem_wb_enable", {31'b0, mem_wb_enable}, {31'b0, e_en});
            cmp("mem_stall", {31'b0, mem_stall}, {31'b0, e_stall});
            cmp("dmem_req", {31'b0, dmem_req}, {31'b0, e_req});
            cmp("misalign_exc", {31'b0, misalign_exc}, {31'b0, e_exc});
            cmp("bus_error", {31'b0, bus_error}, {31'b0, e_berr});
            if (ck_bus) begin
                cmp("dmem_we", {31'b0, dmem_we}, {31'b0, e_we});
                cmp("dmem_addr", dmem_addr, e_addr);
                cmp("dmem_be", {28'b0, dmem_be}, {28'b0, e_be});
            end
            if (ck_wd) cmp("dmem_wdata", dmem_wdata, e_wdata);
            if (ck_wb) begin
                cmp("mem_alu_result", mem_alu_result, e_alu);
                cmp("mem_MemtoReg", {31'b0, mem_MemtoReg}, {31'b0, e_m2r});
                cmp("mem_WriteReg", {27'b0, mem_WriteReg}, {27'b0, e_wreg});
            end
            if (ck_wb || ck_rw) cmp("mem_RegWrite", {31'b0, mem_RegWrite}, {31'b0, e_rw});
            if (ck_rd) cmp("mem_read_data", mem_read_data, e_rd);
            if (mem_stall) stall_cycles++;
            if (dmem_req) begin
                req_cycles++;
                obs_be    = dmem_be;
                obs_addr  = dmem_addr;
                obs_wdata = dmem_wdata;
            end
            if (mem_wb_enable) begin
                obs_rd   = mem_read_data;
                obs_alu  = mem_alu_result;
                obs_wreg = mem_WriteReg;
                obs_rw   = mem_RegWrite;
                obs_berr = bus_error;
                obs_exc  = misalign_exc;
            end
        end
    end

    // ---------------- behavioural model ----------------
    function automatic bit m_ok(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int unsigned nb;
        if (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
        nb = 1 << f3[1:0];
        return (a % nb) == 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * (a % 4))) & 255;
        h = (w >> (16 * ((a % 4) / 2))) & 65535;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned v;
        v = (f3[1:0] == 2'd0) ? (1 << (a % 4)) : (f3[1:0] == 2'd1) ? (3 << (a % 4)) : 15;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1:0] == 2'd0) return (wd & 32'd255) * 32'h01010101;
        if (f3[1:0] == 2'd1) return (wd & 32'd65535) * 32'h00010001;
        return wd;
    endfunction

    task automatic clr_exp();
        {e_en, e_stall, e_req, e_exc, e_berr, e_we, e_m2r, e_rw} = '0;
        {e_addr, e_wdata, e_alu, e_rd} = '0;
        e_be = '0;
        e_wreg = '0;
        {ck_bus, ck_wd, ck_wb, ck_rw, ck_rd} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic m2r,
                            input logic rw, input logic [4:0] wreg, input int waits,
                            input logic [31:0] rdata);
        bit st, tmo;
        ex_mem_valid = v; ex_mem_MemRead = rd; ex_mem_MemWrite = wr;
        ex_mem_funct3 = f3; ex_mem_alu_result = a; ex_mem_write_data = wd;
        ex_mem_MemtoReg = m2r; ex_mem_RegWrite = rw; ex_mem_WriteReg = wreg;
        dmem_ack = 1'($urandom % 2);
        dmem_rdata = $urandom;
        stall_cycles = 0; req_cycles = 0;
        obs_rd = '0; obs_alu = '0; obs_wreg = '0; obs_rw = 1'b0; obs_berr = 1'b0; obs_exc = 1'b0;
        obs_be = '0; obs_addr = '0; obs_wdata = '0;
        clr_exp();
        st = wr && !rd;
        if (!v) begin
            step();
        end else if (!(rd || wr)) begin
            e_en = 1'b1; ck_wb = 1'b1; ck_rd = 1'b1;
            e_alu = a; e_m2r = m2r; e_rw = rw; e_wreg = wreg; e_rd = 32'h0;
            step();
        end else if (!m_ok(st, f3, a)) begin
            e_en = 1'b1; e_exc = 1'b1; ck_rw = 1'b1; e_rw = 1'b0;
            step();
        end else begin
            e_stall = 1'b1;
            step();
            tmo = 1'b1;
            for (int k = 0; k < TO; k++) begin
                clr_exp();
                e_req = 1'b1; e_stall = 1'b1; ck_bus = 1'b1; ck_wd = st;
                e_we = st; e_addr = a & ~32'd3; e_be = m_be(f3, a); e_wdata = m_wdata(f3, wd);
                dmem_ack = (k == waits);
                dmem_rdata = (k == waits) ? rdata : $urandom;
                step();
                if (k == waits) begin
                    tmo = 1'b0;
                    break;
                end
            end
            clr_exp();
            e_en = 1'b1; e_berr = tmo; ck_wb = 1'b1;
            e_alu = a; e_m2r = m2r; e_rw = tmo ? 1'b0 : rw; e_wreg = wreg;
            if (!st && !tmo) begin
                ck_rd = 1'b1;
                e_rd = m_load(f3, a, rdata);
            end
            dmem_ack = 1'($urandom % 2);
            dmem_rdata = $urandom;
            step();
        end
    endtask

    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        bit         v, rd, wr, rw;
        int         kind, waits;
        logic [2:0] f3;
        logic [31:0] a;

        rst_n = 1'b0;
        ex_mem_valid = 1'b1; ex_mem_MemRead = 1'b0; ex_mem_MemWrite = 1'b0;
        ex_mem_funct3 = 3'd0; ex_mem_alu_result = 32'h1234; ex_mem_write_data = 32'h0;
        ex_mem_MemtoReg = 1'b0; ex_mem_RegWrite = 1'b1; ex_mem_WriteReg = 5'd3;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        #23;
        cmp("reset enable", {31'b0, mem_wb_enable}, 32'd0);
        cmp("reset alu_result", mem_alu_result, 32'd0);
        cmp("reset RegWrite", {31'b0, mem_RegWrite}, 32'd0);
        cmp("reset req", {31'b0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_on = 1'b1;

        // pin the model with hand-computed values
        cmp("model LB", m_load(3'd0, 32'h103, 32'h80123456), 32'hFFFFFF80);
        cmp("model SH be", {28'b0, m_be(3'd1, 32'h102)}, 32'h0000000C);

        do_instr(1, 1, 0, 3'd2, 32'h100, 32'h0, 1, 1, 5'd4, 0, 32'hDEADBEEF);
        cmp("LW read_data", obs_rd, 32'hDEADBEEF);
        cmp("LW be", {28'b0, obs_be}, 32'hF);
        cmp("LW stall cycles", stall_cycles, 2);

        do_instr(1, 1, 0, 3'd0, 32'h103, 32'h0, 1, 1, 5'd5, 1, 32'h80123456);
        cmp("LB read_data", obs_rd, 32'hFFFFFF80);
        do_instr(1, 1, 0, 3'd4, 32'h103, 32'h0, 1, 1, 5'd5, 0, 32'h80123456);
        cmp("LBU read_data", obs_rd, 32'h00000080);

        do_instr(1, 0, 1, 3'd1, 32'h102, 32'h0000ABCD, 0, 0, 5'd0, 2, 32'h0);
        cmp("SH be", {28'b0, obs_be}, 32'hC);
        cmp("SH wdata", obs_wdata, 32'hABCDABCD);
        cmp("SH addr", obs_addr, 32'h100);
        cmp("SH stall cycles", stall_cycles, 4);

        do_instr(1, 1, 0, 3'd2, 32'h101, 32'h0, 1, 1, 5'd6, 0, 32'h0);
        cmp("misalign exc", {31'b0, obs_exc}, 32'd1);
        cmp("misalign req cycles", req_cycles, 0);
        cmp("misalign stall cycles", stall_cycles, 0);

        do_instr(1, 0, 0, 3'd0, 32'h5, 32'h0, 0, 1, 5'd7, 0, 32'h0);
        cmp("ADD alu", obs_alu, 32'h5);
        cmp("ADD rd", {27'b0, obs_wreg}, 32'd7);

        do_instr(1, 1, 0, 3'd2, 32'h200, 32'h0, 1, 1, 5'd8, 99, 32'h0);
        cmp("timeout req cycles", req_cycles, TO);
        cmp("timeout bus_error", {31'b0, obs_berr}, 32'd1);
        cmp("timeout RegWrite", {31'b0, obs_rw}, 32'd0);

        // reset in the middle of an outstanding request
        ex_mem_valid = 1'b1; ex_mem_MemRead = 1'b1; ex_mem_MemWrite = 1'b0;
        ex_mem_funct3 = 3'd2; ex_mem_alu_result = 32'h300; dmem_ack = 1'b0;
        clr_exp(); e_stall = 1'b1;
        step();
        clr_exp(); e_req = 1'b1; e_stall = 1'b1;
        step();
        cmp("midreq req before reset", {31'b0, dmem_req}, 32'd1);
        chk_on = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        cmp("midreq req in reset", {31'b0, dmem_req}, 32'd0);
        cmp("midreq stall in reset", {31'b0, mem_stall}, 32'd0);
        cmp("midreq enable in reset", {31'b0, mem_wb_enable}, 32'd0);
        ex_mem_valid = 1'b0;
        step();
        rst_n = 1'b1;
        clr_exp();
        chk_on = 1'b1;
        step();
        step();
        cmp("post-reset idle req", {31'b0, dmem_req}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            v = ($urandom % 8) != 0;
            kind = int'($urandom % 10);
            rd = (kind >= 3) && (kind <= 6);
            wr = kind >= 7;
            if ($urandom % 8 == 0) f3 = 3'($urandom);
            else if (wr) f3 = 3'($urandom % 3);
            else f3 = ld_f3[$urandom % 5];
            a = $urandom;
            if ($urandom % 2 == 1) a = a & ~32'd3;
            rw = wr ? 1'b0 : (rd ? 1'b1 : 1'($urandom % 2));
            waits = ($urandom % 8 == 0) ? 99 : int'($urandom % 4);
            do_instr(v, rd, wr, f3, a, $urandom, rd, rw, 5'($urandom), waits, $urandom);
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
